// File: rtl/jt12_eg_pkg.sv
// jt12_eg_pkg: shared EG constants, channel-code decode and slot-index helpers
package jt12_eg_pkg;
  localparam int SLOTS = 24;
  localparam int CHANNELS = 6;
  // operator S1,S2,S3,S4 -> slot group (groups run S1,S3,S2,S4)
  localparam logic [1:0] OP_GRP [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
  typedef enum logic [2:0] {ATTACK, DECAY1, DECAY2, HOLD, RELEASE} eg_state_t;
  typedef struct packed {
    logic valid;
    logic [2:0] ch;
  } ch_dec_t;
  function automatic ch_dec_t ch_decode(logic [2:0] code);
    ch_decode.valid = code[1:0] != 2'd3;
    ch_decode.ch = code[2] ? {1'b0, code[1:0]} + 3'd3 : {1'b0, code[1:0]};
  endfunction
  function automatic logic [4:0] kon_idx(logic [1:0] grp, logic [2:0] ch);
    return {3'b0, grp} * 5'd6 + {2'b0, ch};
  endfunction
endpackage

// File: rtl/jt12_eg_sched_if.sv
// jt12_eg_sched_if: CPU key-on write port and EG slot/keyon outputs (CSM inputs under JT12_EG_SCHED_CSM_EN)
interface jt12_eg_sched_if;
  logic wr_kon;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;
  logic kon_busy;
  logic kon_ovf;
  logic [4:0] slot;
  logic zero;
  logic keyon_II;
  logic [4:0] slot_II;
`ifdef JT12_EG_SCHED_CSM_EN
  logic csm_en;
  logic timer_a_ovf;
  modport master(output wr_kon, kon_ch, kon_op, csm_en, timer_a_ovf,
                 input kon_busy, kon_ovf, slot, zero, keyon_II, slot_II);
  modport slave(input wr_kon, kon_ch, kon_op, csm_en, timer_a_ovf,
                output kon_busy, kon_ovf, slot, zero, keyon_II, slot_II);
`else
  modport master(output wr_kon, kon_ch, kon_op,
                 input kon_busy, kon_ovf, slot, zero, keyon_II, slot_II);
  modport slave(input wr_kon, kon_ch, kon_op,
                output kon_busy, kon_ovf, slot, zero, keyon_II, slot_II);
`endif
endinterface

// File: rtl/jt12_slot_cnt.sv
// jt12_slot_cnt: slot counter with ch/grp sub-counters and once-per-frame zero
module jt12_slot_cnt
  import jt12_eg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] slot,
  output logic [2:0] ch,
  output logic [1:0] grp,
  output logic       zero
);
  assign zero = slot == 5'(SLOTS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      ch <= '0;
      grp <= '0;
    end else begin
      slot <= zero ? 5'd0 : slot + 5'd1;
      ch <= ch == 3'(CHANNELS - 1) ? 3'd0 : ch + 3'd1;
      grp <= ch == 3'(CHANNELS - 1) ? grp + 2'd1 : grp;
    end
  end
endmodule

// File: rtl/jt12_eg_sched.sv
// jt12_eg_sched: slot sequencer and frame-aligned key-on scheduler; CSM key-on under JT12_EG_SCHED_CSM_EN
module jt12_eg_sched
  import jt12_eg_pkg::*;
(
  input logic clk,
  input logic rst,
  jt12_eg_sched_if.slave bus
);
  logic [4:0] slot;
  logic [2:0] ch;
  logic [1:0] grp;
  logic zero, busy, acc, csm_key;
  logic [23:0] kon_reg;
  logic [2:0] pend_ch;
  logic [3:0] pend_op;
  ch_dec_t dec;
  jt12_slot_cnt u_cnt (.clk(clk), .rst(rst), .slot(slot), .ch(ch), .grp(grp), .zero(zero));
  assign dec = ch_decode(bus.kon_ch);
  assign acc = bus.wr_kon & ~busy & dec.valid;
  assign bus.kon_busy = busy;
  assign bus.slot = slot;
  assign bus.zero = zero;
`ifdef JT12_EG_SCHED_CSM_EN
  logic arm, act, trig;
  assign trig = bus.timer_a_ovf & bus.csm_en;
  assign csm_key = act & (ch == 3'd2);
  // act covers exactly the frame after the boundary that saw arm
  always_ff @(posedge clk) begin
    if (rst) begin
      arm <= 1'b0;
      act <= 1'b0;
    end else begin
      arm <= zero ? trig : arm | trig;
      act <= zero ? arm : act;
    end
  end
`else
  assign csm_key = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      kon_reg <= '0;
      busy <= 1'b0;
      pend_ch <= '0;
      pend_op <= '0;
      bus.kon_ovf <= 1'b0;
      bus.keyon_II <= 1'b0;
      bus.slot_II <= '0;
    end else begin
      bus.keyon_II <= kon_reg[kon_idx(grp, ch)] | csm_key;
      bus.slot_II <= slot;
      bus.kon_ovf <= bus.wr_kon & busy;
      if (zero && busy)
        for (int i = 0; i < 4; i++) kon_reg[kon_idx(OP_GRP[i], pend_ch)] <= pend_op[i];
      busy <= acc | (busy & ~zero);
      if (acc) begin
        pend_ch <= dec.ch;
        pend_op <= bus.kon_op;
      end
    end
  end
endmodule
